// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary to packed BCD converter
// with saturation, overflow flag and leading-zero mask for display blanking.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic [DIGITS-1:0]     lz_mask
);

  localparam int MAXV = (DIGITS == 1) ? 9 :
                        (DIGITS == 2) ? 99 :
                        (DIGITS == 3) ? 999 : 9999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  state_t state_q, state_d;

  logic [19:0]          scr_q, scr_d;
  logic [19:0]          adj;
  logic [WIDTH-1:0]     sh_q, sh_d;
  logic [WIDTH+19:0]    shifted;
  logic [4:0]           cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_d;
  logic                 done_d;
  logic [4*DIGITS-1:0]  bcd_d;
  logic                 oflow_d;
  logic [DIGITS-1:0]    lz_d;
  logic [DIGITS-1:0]    lz_calc;
  logic [4*DIGITS-1:0]  val;
  logic [31:0]          bin_ext;
  logic                 over_max;
  logic                 zero_run;

  // Add-3 correction on every scratch digit that is 5 or more.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < 5; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  // Saturated result and its leading-zero mask, as written at LATCH.
  always_comb begin
    val      = ovf_q ? {DIGITS{4'h9}} : scr_q[4*DIGITS-1:0];
    lz_calc  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (val[4*i +: 4] == 4'd0);
      lz_calc[i] = zero_run;
    end
  end

  assign bin_ext  = 32'(bin_in);
  assign over_max = bin_ext > 32'(MAXV);
  assign shifted  = {adj, sh_q} << 1;

  // Next-state and next-output logic of the conversion FSM.
  always_comb begin
    state_d = state_q;
    scr_d   = scr_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    busy_d  = busy;
    done_d  = 1'b0;
    bcd_d   = bcd_out;
    oflow_d = overflow;
    lz_d    = lz_mask;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sh_d    = bin_in;
          scr_d   = '0;
          ovf_d   = over_max;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = shifted[WIDTH+19 -: 20];
        sh_d  = shifted[WIDTH-1:0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(WIDTH - 1))
          state_d = LATCH;
      end
      LATCH: begin
        bcd_d   = val;
        oflow_d = ovf_q;
        lz_d    = lz_calc;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, scratch and output registers; reset aborts any conversion.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      scr_q    <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      lz_mask  <= '0;
    end else begin
      state_q  <= state_d;
      scr_q    <= scr_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      busy     <= busy_d;
      done     <= done_d;
      bcd_out  <= bcd_d;
      overflow <= oflow_d;
      lz_mask  <= lz_d;
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench for the sequential BCD converter
// with default WIDTH=16, DIGITS=4.
module tb_bin_to_bcd_seq;

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  mask;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        overflow;
  logic [3:0]  lz_mask;

  exp_t q[$];
  int   tests;
  int   fails;

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow),
    .lz_mask  (lz_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic exp_t model(input int v);
    exp_t e;
    int   t;
    e = '0;
    if (v > 9999) begin
      e.bcd = 16'h9999;
      e.ovf = 1'b1;
    end else begin
      t = v;
      for (int i = 0; i < 4; i++) begin
        e.bcd[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
      e.mask[3] = (v < 1000);
      e.mask[2] = (v < 100);
      e.mask[1] = (v < 10);
    end
    return e;
  endfunction

  task automatic start_conv(input logic [15:0] v);
    start  = 1'b1;
    bin_in = v;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc, output int bcyc);
    cyc  = c0;
    bcyc = busy ? 1 : 0;
    while (!done && cyc < 60) begin
      tick();
      cyc++;
      if (busy) bcyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    bin_in = '0;
    tick();
    tick();
    tests++;
    if ({busy, done, overflow} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: got %b want 000", {busy, done, overflow});
    end
    tests++;
    if (bcd_out !== 16'h0000) begin
      fails++;
      $display("FAIL reset_bcd: got %h want 0000", bcd_out);
    end
    tests++;
    if (lz_mask !== 4'b0000) begin
      fails++;
      $display("FAIL reset_lz: got %b want 0000", lz_mask);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_value(input int v, input string nm);
    int   cyc, bcyc;
    exp_t e;
    q.push_back(model(v));
    start_conv(16'(v));
    wait_done(0, cyc, bcyc);
    tests++;
    if (cyc !== 17) begin
      fails++;
      $display("FAIL %s_latency: got %0d want 17", nm, cyc);
    end
    tests++;
    if (bcyc !== 17) begin
      fails++;
      $display("FAIL %s_busy_len: got %0d want 17", nm, bcyc);
    end
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL %s_scoreboard: got empty want entry", nm);
    end else begin
      e = q.pop_front();
      if (bcd_out !== e.bcd) begin
        fails++;
        $display("FAIL %s_bcd: got %h want %h", nm, bcd_out, e.bcd);
      end
      tests++;
      if (overflow !== e.ovf) begin
        fails++;
        $display("FAIL %s_ovf: got %b want %b", nm, overflow, e.ovf);
      end
      tests++;
      if (lz_mask !== e.mask) begin
        fails++;
        $display("FAIL %s_lz: got %b want %b", nm, lz_mask, e.mask);
      end
    end
    tick();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL %s_done_pulse: got %b want 0", nm, done);
    end
  endtask

  task automatic test_back_to_back();
    int   vals[3];
    int   cyc, bcyc;
    exp_t e;
    vals[0] = 9999;
    vals[1] = 10000;
    vals[2] = 65535;
    for (int j = 0; j < 3; j++) q.push_back(model(vals[j]));
    start_conv(16'(vals[0]));
    for (int j = 0; j < 3; j++) begin
      wait_done(0, cyc, bcyc);
      tests++;
      if (cyc !== 17) begin
        fails++;
        $display("FAIL b2b%0d_latency: got %0d want 17", j, cyc);
      end
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL b2b%0d_scoreboard: got empty want entry", j);
      end else begin
        e = q.pop_front();
        if (bcd_out !== e.bcd) begin
          fails++;
          $display("FAIL b2b%0d_bcd: got %h want %h", j, bcd_out, e.bcd);
        end
        tests++;
        if (overflow !== e.ovf) begin
          fails++;
          $display("FAIL b2b%0d_ovf: got %b want %b", j, overflow, e.ovf);
        end
        tests++;
        if (lz_mask !== e.mask) begin
          fails++;
          $display("FAIL b2b%0d_lz: got %b want %b", j, lz_mask, e.mask);
        end
      end
      if (j < 2) begin
        start_conv(16'(vals[j+1]));
        tests++;
        if (busy !== 1'b1) begin
          fails++;
          $display("FAIL b2b%0d_no_dead: got busy %b want 1", j, busy);
        end
      end
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int   cyc, bcyc, extra;
    exp_t e;
    q.push_back(model(1234));
    start_conv(16'd1234);
    repeat (4) tick();
    start  = 1'b1;
    bin_in = 16'd5678;
    tick();
    start  = 1'b0;
    bin_in = 16'd0;
    wait_done(5, cyc, bcyc);
    tests++;
    if (cyc !== 17) begin
      fails++;
      $display("FAIL ign_latency: got %0d want 17", cyc);
    end
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL ign_scoreboard: got empty want entry");
    end else begin
      e = q.pop_front();
      if (bcd_out !== e.bcd) begin
        fails++;
        $display("FAIL ign_bcd: got %h want %h", bcd_out, e.bcd);
      end
    end
    extra = 0;
    repeat (30) begin
      tick();
      if (done || busy) extra++;
    end
    tests++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL ign_second_conv: got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int   cyc, bcyc, dn;
    exp_t e;
    start_conv(16'd4321);
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if ({busy, done, overflow} !== 3'b000) begin
      fails++;
      $display("FAIL rst_mid_flags: got %b want 000", {busy, done, overflow});
    end
    tests++;
    if (bcd_out !== 16'h0000) begin
      fails++;
      $display("FAIL rst_mid_bcd: got %h want 0000", bcd_out);
    end
    dn = 0;
    repeat (30) begin
      tick();
      if (done) dn++;
    end
    tests++;
    if (dn !== 0) begin
      fails++;
      $display("FAIL rst_mid_done: got %0d want 0", dn);
    end
    q.push_back(model(77));
    start_conv(16'd77);
    wait_done(0, cyc, bcyc);
    tests++;
    if (cyc !== 17) begin
      fails++;
      $display("FAIL rst77_latency: got %0d want 17", cyc);
    end
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL rst77_scoreboard: got empty want entry");
    end else begin
      e = q.pop_front();
      if (bcd_out !== e.bcd) begin
        fails++;
        $display("FAIL rst77_bcd: got %h want %h", bcd_out, e.bcd);
      end
      tests++;
      if (lz_mask !== e.mask) begin
        fails++;
        $display("FAIL rst77_lz: got %b want %b", lz_mask, e.mask);
      end
    end
    tick();
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    test_reset();
    test_value(0, "zero");
    test_value(1234, "v1234");
    test_value(42, "v42");
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_left: got %0d want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
